// File: rtl/pilots_remove.sv
// pilots_remove: receive-side pilot/null stripper.
// Consumes one FFT symbol of N subcarriers in natural order and forwards
// only the data subcarriers. Pilot subcarriers are dropped and flagged on
// PIL_O. The STD / ALLOC_VEC configuration is shadowed and takes effect
// only at a symbol boundary.
module pilots_remove (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic [31:0]   DAT_I,
  input  logic          CYC_I,
  input  logic          STB_I,
  input  logic          WE_I,
  output logic          ACK_O,
  output logic [31:0]   DAT_O,
  output logic          CYC_O,
  output logic          STB_O,
  output logic          WE_O,
  input  logic          ACK_I,
  input  logic [1:0]    STD,
  input  logic [4095:0] ALLOC_VEC,
  input  logic          VEC_LD,
  output logic          PIL_O,
  output logic          SYM_END_O
);

  typedef enum logic [1:0] {
    SC_NULL  = 2'b00,
    SC_DATA  = 2'b01,
    SC_PILOT = 2'b10,
    SC_RSVD  = 2'b11
  } sc_class_e;

  logic [10:0]   idx_q,      idx_d;
  logic [1:0]    act_std_q,  act_std_d;
  logic [4095:0] act_vec_q,  act_vec_d;
  logic [1:0]    pend_std_q, pend_std_d;
  logic [4095:0] pend_vec_q, pend_vec_d;
  logic          pend_q,     pend_d;
  logic [31:0]   dat_q,      dat_d;
  logic          stb_q,      stb_d;
  logic          pil_q,      pil_d;
  logic          sym_end_q,  sym_end_d;

  logic [10:0] last_idx;
  logic        is_last;
  logic        promote;
  logic        up_xfer;
  logic        dn_xfer;
  sc_class_e   sc_class;

  // Handshake, symbol length and classification of the current subcarrier.
  always_comb begin
    unique case (act_std_q)
      2'b00:   last_idx = 11'd63;
      2'b01:   last_idx = 11'd255;
      2'b10:   last_idx = 11'd1023;
      default: last_idx = 11'd2047;
    endcase
    is_last  = (idx_q == last_idx);
    // The config copy only happens between symbols and steals that cycle
    // from upstream, so no sample is ever classified with a half-swapped map.
    promote  = pend_q & (idx_q == 11'd0);
    ACK_O    = CYC_I & STB_I & WE_I & (~stb_q | ACK_I) & ~promote;
    up_xfer  = CYC_I & STB_I & WE_I & ACK_O;
    dn_xfer  = stb_q & ACK_I;
    sc_class = sc_class_e'(act_vec_q[{idx_q, 1'b0} +: 2]);
  end

  // Next-state logic for config shadow, index and output register.
  always_comb begin
    // NOTE: every _d gets a default before any branch; a path that leaves a
    // combinational variable unassigned would infer a latch.
    idx_d      = idx_q;
    act_std_d  = act_std_q;
    act_vec_d  = act_vec_q;
    pend_std_d = pend_std_q;
    pend_vec_d = pend_vec_q;
    pend_d     = pend_q;
    dat_d      = dat_q;
    stb_d      = stb_q;
    pil_d      = 1'b0;
    sym_end_d  = 1'b0;

    if (promote) begin
      act_std_d = pend_std_q;
      act_vec_d = pend_vec_q;
    end

    // A load in the promote cycle must survive as the next pending config.
    if (VEC_LD) begin
      pend_std_d = STD;
      pend_vec_d = ALLOC_VEC;
      pend_d     = 1'b1;
    end else if (promote) begin
      pend_d = 1'b0;
    end

    if (up_xfer) begin
      idx_d     = is_last ? 11'd0 : idx_q + 11'd1;
      sym_end_d = is_last;
      pil_d     = (sc_class == SC_PILOT);
    end else if (!CYC_I) begin
      // Upstream abandoned the symbol; restart at subcarrier 0.
      idx_d = 11'd0;
    end

    if (up_xfer && sc_class == SC_DATA) begin
      dat_d = DAT_I;
      stb_d = 1'b1;
    end else if (dn_xfer) begin
      stb_d = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK_I) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge regardless of order.
    if (RST_I) begin
      // NOTE: the wide map registers are reset as well, because the block
      // must come out of reset with an all-null map.
      idx_q      <= '0;
      act_std_q  <= '0;
      act_vec_q  <= '0;
      pend_std_q <= '0;
      pend_vec_q <= '0;
      pend_q     <= 1'b0;
      dat_q      <= '0;
      stb_q      <= 1'b0;
      pil_q      <= 1'b0;
      sym_end_q  <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      act_std_q  <= act_std_d;
      act_vec_q  <= act_vec_d;
      pend_std_q <= pend_std_d;
      pend_vec_q <= pend_vec_d;
      pend_q     <= pend_d;
      dat_q      <= dat_d;
      stb_q      <= stb_d;
      pil_q      <= pil_d;
      sym_end_q  <= sym_end_d;
    end
  end

  assign DAT_O     = dat_q;
  assign STB_O     = stb_q;
  assign WE_O      = stb_q;
  assign CYC_O     = stb_q | (idx_q != 11'd0);
  assign PIL_O     = pil_q;
  assign SYM_END_O = sym_end_q;

endmodule

// File: doc/pilots_remove.md
# pilots_remove

Receive-side counterpart of the transmit pilot inserter. It sits between the receiver FFT and the QPSK demapper and consumes one frequency-domain symbol of N subcarriers in natural order. Using the same STD / ALLOC_VEC configuration that the transmitter's config registers produce, it drops null and pilot subcarriers, flags pilots on a side strobe, and forwards only data subcarriers on a Wishbone-style output port.

## Interface
- No parameters. Widths are fixed to match the transmit chain: max 2048 subcarriers, 2 bits each.
- CLK_I  in  1  single clock, rising edge.
- RST_I  in  1  reset, synchronous, active-high.
- DAT_I  in  32  subcarrier sample: [31:16] I, [15:0] Q, two's complement.
- CYC_I  in  1  upstream cycle (symbol in progress).
- STB_I  in  1  upstream strobe.
- WE_I  in  1  must be 1 for a transfer; samples with WE_I=0 are never acknowledged.
- ACK_O  out  1  upstream acknowledge, combinational.
- DAT_O  out  32  data subcarrier, same format as DAT_I.
- CYC_O  out  1  downstream cycle.
- STB_O  out  1  downstream strobe.
- WE_O  out  1  equals STB_O.
- ACK_I  in  1  downstream acknowledge.
- STD  in  2  FFT size: 00=64, 01=256, 10=1024, 11=2048.
- ALLOC_VEC  in  4096  subcarrier map; bits [2k+1:2k] describe subcarrier k: 00 null, 01 data, 10 pilot, 11 treated as null.
- VEC_LD  in  1  one-cycle pulse; STD and ALLOC_VEC are valid on this cycle.
- PIL_O  out  1  one-cycle pulse on acceptance of a pilot subcarrier.
- SYM_END_O  out  1  one-cycle pulse on acceptance of subcarrier N-1.

## Operation
- **Config shadow.**
  - On VEC_LD the block captures STD and ALLOC_VEC into a pending register and sets pend flag.
  - Pending config is copied to the active config when the subcarrier index is 0 and no upstream transfer happens that cycle, i.e. only at a symbol boundary.
  - If VEC_LD coincides with acceptance of subcarrier N-1, the new config applies to the next symbol.
  - A second VEC_LD before promotion overwrites the pending config.
- **Transfers.**
  - Upstream transfer = CYC_I & STB_I & WE_I & ACK_O.
  - Downstream transfer = STB_O & ACK_I.
- **Index.**
  - idx (11 bits) starts at 0 and increments on each upstream transfer.
  - idx wraps to 0 after N-1, where N comes from the active STD; SYM_END_O pulses on that transfer.
- **Classification** uses the active ALLOC_VEC[2·idx+1 : 2·idx].
  - Data: the sample is loaded into the output register and STB_O is set.
  - Pilot: the sample is dropped and PIL_O pulses.
  - Null/reserved: the sample is dropped.
- **Acknowledge.**
  - ACK_O = CYC_I & STB_I & WE_I & (~STB_O | ACK_I) & ~promote, where promote is the cycle in which the config copy occurs.
  - Non-data subcarriers also wait for this condition, so ordering is kept simple.
- **Output register.**
  - STB_O clears on a downstream transfer unless a new data sample loads in the same cycle; back-to-back streaming is allowed.
- **CYC_O** = STB_O | (idx != 0).
- **Upstream abort.** If CYC_I deasserts while idx != 0:
  - idx resets to 0 on the next edge and the partial symbol is abandoned.
  - No SYM_END_O pulse is produced.
  - A sample already held in the output register is still delivered.
- **Reset.**
  - idx=0; active and pending STD=00, ALLOC_VEC all zero (all null), pend=0.
  - STB_O=0, DAT_O=0, CYC_O=0, WE_O=0, PIL_O=0, SYM_END_O=0.
  - ACK_O follows its equation.
  - Reset mid-symbol discards everything, including the held output sample.

## Timing
- Latency is 1 cycle: a data sample accepted at edge t appears on DAT_O/STB_O after edge t.
- Throughput is 1 sample/cycle with ACK_I held high.
- Output stall: when STB_O=1 and ACK_I=0, ACK_O=0 and DAT_O is held stable.
- PIL_O and SYM_END_O are registered and assert the cycle after the accepting edge.
- Config promotion costs 1 cycle (ACK_O=0) only when pend=1 at a boundary; otherwise there is no boundary bubble.

## Test plan
- **Pilot/null stripping.** VEC_LD with STD=00 and a map where subcarriers 0–5 and 59–63 are null, 11/25/39/53 are pilots, and the rest are data. Stream 64 samples with DAT_I=idx and ACK_I=1 -> exactly 49 outputs in increasing idx order, 4 PIL_O pulses, 1 SYM_END_O, CYC_O low after the last output.
- **Back-pressure.** Same map, ACK_I toggling 1,0,0,1 repeatedly -> no sample lost or duplicated, DAT_O stable while stalled, 49 outputs.
- **Mid-symbol VEC_LD.** Pulse VEC_LD at idx=30 with STD=01 and an all-data map -> the rest of the current symbol uses the old 64-entry map; the next symbol yields 256 outputs, preceded by one ACK_O=0 bubble at idx=0.
- **Abort.** CYC_I drops at idx=20 -> idx returns to 0, no SYM_END_O, pending output delivered. The next symbol restarts at subcarrier 0 with correct classification.
- **Reset.** Assert RST_I mid-symbol with STB_O=1 -> STB_O=0 after the edge. After reset, 64 input samples give zero outputs (all-null map) until VEC_LD.
- **Max size.** STD=11, alternating data/pilot map -> 1024 outputs, 1024 PIL_O pulses, idx wraps at 2047.
